// File: rtl/sram_byte_writer.sv
// ============================================================================
// sram_byte_writer : byte stream to 256x32b byte-lane SRAM write initiator
// Revision 1.0
// ============================================================================
`default_nettype none

module sram_byte_writer #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 256,
  parameter int LEN_W  = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  num_bytes,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              sram_csb,
  output logic              sram_wsb,
  output logic [3:0]        sram_bytemask,
  output logic [7:0]        sram_wdata,
  output logic [ADDR_W-1:0] sram_waddr,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] C_LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        lane_q, lane_d;
  logic              csb_q, csb_d;
  logic              wsb_q, wsb_d;
  logic [3:0]        mask_q, mask_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic              done_q, done_d;
  logic              hs;

  assign in_ready = (state_q == S_WRITE);
  assign busy     = (state_q != S_IDLE);
  assign hs       = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    lane_d  = lane_q;
    csb_d   = 1'b1;
    wsb_d   = 1'b1;
    mask_d  = 4'b0000;
    wdata_d = wdata_q;
    waddr_d = waddr_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d = base_addr;
          cnt_d  = num_bytes;
          lane_d = 2'd3;
          if (num_bytes == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_WRITE;
          end
        end
      end

      S_WRITE: begin
        if (hs) begin
          // Mask is derived only from a 2-bit lane, so a strobe is always one-hot.
          csb_d   = 1'b0;
          wsb_d   = 1'b0;
          mask_d  = 4'b0001 << lane_q;
          wdata_d = in_data;
          waddr_d = addr_q;
          cnt_d   = cnt_q - LEN_W'(1);
          if (lane_q == 2'd0) begin
            lane_d = 2'd3;
            addr_d = (addr_q >= C_LAST_ADDR) ? '0 : addr_q + ADDR_W'(1);
          end else begin
            lane_d = lane_q - 2'd1;
          end
          if (cnt_q == LEN_W'(1)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      lane_q  <= 2'd0;
      csb_q   <= 1'b1;
      wsb_q   <= 1'b1;
      mask_q  <= 4'b0000;
      wdata_q <= 8'h00;
      waddr_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      lane_q  <= lane_d;
      csb_q   <= csb_d;
      wsb_q   <= wsb_d;
      mask_q  <= mask_d;
      wdata_q <= wdata_d;
      waddr_q <= waddr_d;
      done_q  <= done_d;
    end
  end

  assign sram_csb      = csb_q;
  assign sram_wsb      = wsb_q;
  assign sram_bytemask = mask_q;
  assign sram_wdata    = wdata_q;
  assign sram_waddr    = waddr_q;
  assign done          = done_q;

endmodule

`default_nettype wire

// File: tb/tb_sram_byte_writer.sv
// ============================================================================
// tb_sram_byte_writer : randomized self-checking bench with behavioural model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_sram_byte_writer;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 256;
  localparam int LEN_W  = 11;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [LEN_W-1:0]  num_bytes;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              sram_csb;
  logic              sram_wsb;
  logic [3:0]        sram_bytemask;
  logic [7:0]        sram_wdata;
  logic [ADDR_W-1:0] sram_waddr;
  logic              busy;
  logic              done;

  sram_byte_writer #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .base_addr     (base_addr),
    .num_bytes     (num_bytes),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .sram_csb      (sram_csb),
    .sram_wsb      (sram_wsb),
    .sram_bytemask (sram_bytemask),
    .sram_wdata    (sram_wdata),
    .sram_waddr    (sram_waddr),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] mem     [DEPTH];
  logic [31:0] exp_mem [DEPTH];
  logic [7:0]  tx      [1024];
  int          strobe_total = 0;
  int          done_total   = 0;
  int          pre_seq      = 0;
  int          pre_addr     = 0;
  logic [31:0] pre_val      = 32'h0;

  // SRAM model, behavioural reference model and per-cycle compare.
  initial begin : monitor
    bit          chk_en;
    int          seen_seq;
    int          m_base, m_len, m_idx, wa, ln;
    logic        e_ready, e_busy, e_done, e_csb, e_wsb;
    logic [3:0]  e_mask;
    logic [7:0]  e_wdata;
    logic [ADDR_W-1:0] e_waddr;
    logic        n_ready, n_busy, n_done, n_csb, n_wsb;
    logic [3:0]  n_mask;
    logic [7:0]  n_wdata;
    logic [ADDR_W-1:0] n_waddr;
    chk_en = 0; seen_seq = 0; m_base = 0; m_len = 0; m_idx = 0;
    e_ready = 0; e_busy = 0; e_done = 0; e_csb = 1; e_wsb = 1;
    e_mask = 0; e_wdata = 0; e_waddr = 0;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = 32'h0;
      exp_mem[i] = 32'h0;
    end
    forever begin
      @(negedge clk);
      if (pre_seq != seen_seq) begin
        seen_seq = pre_seq;
        mem[pre_addr] = pre_val;
        exp_mem[pre_addr] = pre_val;
      end
      if (sram_csb === 1'b0 && sram_wsb === 1'b0) begin
        strobe_total++;
        if ($onehot(sram_bytemask)) begin
          for (int l = 0; l < 4; l++)
            if (sram_bytemask[l]) mem[sram_waddr[7:0]][l*8 +: 8] = sram_wdata;
        end else begin
          mem[sram_waddr[7:0]] = 32'h0;
        end
      end
      if (done === 1'b1) done_total++;
      if (sram_wsb === 1'b0) begin
        n_tests++;
        if (!($onehot(sram_bytemask) && sram_csb === 1'b0)) begin
          n_fail++;
          $display("FAIL mask_invariant t=%0t actual mask=%b csb=%b required one-hot mask with csb=0",
                   $time, sram_bytemask, sram_csb);
        end
      end
      if (chk_en) begin
        n_tests++;
        if ({in_ready, busy, done, sram_csb, sram_wsb, sram_bytemask, sram_wdata, sram_waddr} !==
            {e_ready, e_busy, e_done, e_csb, e_wsb, e_mask, e_wdata, e_waddr}) begin
          n_fail++;
          $display("FAIL cycle_outputs t=%0t actual rdy=%b busy=%b done=%b csb=%b wsb=%b mask=%b wdata=%h waddr=%0d required rdy=%b busy=%b done=%b csb=%b wsb=%b mask=%b wdata=%h waddr=%0d",
                   $time, in_ready, busy, done, sram_csb, sram_wsb, sram_bytemask, sram_wdata, sram_waddr,
                   e_ready, e_busy, e_done, e_csb, e_wsb, e_mask, e_wdata, e_waddr);
        end
      end
      // Predict the outputs after the coming rising edge.
      n_ready = e_ready; n_busy = e_busy; n_done = 1'b0;
      n_csb = 1'b1; n_wsb = 1'b1; n_mask = 4'b0000;
      n_wdata = e_wdata; n_waddr = e_waddr;
      if (rst) begin
        n_ready = 0; n_busy = 0; n_wdata = 0; n_waddr = 0;
        chk_en = 1;
      end else if (!e_busy) begin
        if (start) begin
          m_base = int'(base_addr); m_len = int'(num_bytes); m_idx = 0;
          n_busy  = 1;
          n_ready = (m_len != 0);
          n_done  = (m_len == 0);
        end
      end else if (e_ready) begin
        if (in_valid) begin
          wa = (m_base + m_idx / 4) % DEPTH;
          ln = 3 - (m_idx % 4);
          n_csb = 0; n_wsb = 0;
          n_mask  = 4'(1 << ln);
          n_wdata = in_data;
          n_waddr = ADDR_W'(wa);
          exp_mem[wa][ln*8 +: 8] = in_data;
          m_idx++;
          if (m_idx == m_len) begin
            n_ready = 0;
            n_done  = 1;
          end
        end
      end else begin
        n_busy = 0;
      end
      e_ready = n_ready; e_busy = n_busy; e_done = n_done; e_csb = n_csb; e_wsb = n_wsb;
      e_mask = n_mask; e_wdata = n_wdata; e_waddr = n_waddr;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int b, input int n);
    start = 1'b1;
    base_addr = ADDR_W'(b);
    num_bytes = LEN_W'(n);
    tick();
    start = 1'b0;
  endtask

  // Sends tx[0..n-1]; pct is the per-cycle in_valid probability. Returns cycles used.
  task automatic send(input int n, input int pct, output int cyc);
    int  sent;
    bit  hs;
    sent = 0; cyc = 0;
    while (sent < n && cyc < 5000) begin
      in_valid = ($urandom_range(99) < pct);
      in_data  = tx[sent];
      @(negedge clk);
      hs = in_valid && in_ready;
      tick();
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      if (hs) sent++;
      cyc++;
    end
    chk("bytes_sent", 64'(sent), 64'(n));
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    @(negedge clk);
    while (busy && c < 3000) begin
      @(negedge clk);
      c++;
    end
    chk("idle_timeout", 64'(busy), 64'(0));
    tick();
  endtask

  task automatic mem_all(input string name);
    int mism;
    mism = 0;
    for (int i = 0; i < DEPTH; i++)
      if (mem[i] !== exp_mem[i]) mism++;
    chk(name, 64'(mism), 64'(0));
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int s0, d0, cyc;
    bit pat [7];
    rst = 1'b1; start = 1'b0; base_addr = '0; num_bytes = '0;
    in_valid = 1'b0; in_data = 8'h00;
    repeat (3) tick();
    @(negedge clk);
    chk("reset_state", {in_ready, sram_csb, sram_wsb, sram_bytemask, sram_wdata, sram_waddr, busy, done},
        {1'b0, 1'b1, 1'b1, 4'b0000, 8'h00, 10'd0, 1'b0, 1'b0});
    tick();
    rst = 1'b0;
    tick();

    // Basic pack
    s0 = strobe_total; d0 = done_total;
    for (int i = 0; i < 8; i++) tx[i] = 8'(8'h11 + i);
    do_start(5, 8);
    send(8, 100, cyc);
    chk("basic_cycles", 64'(cyc), 64'(8));
    wait_idle();
    chk("basic_strobes", 64'(strobe_total - s0), 64'(8));
    chk("basic_done", 64'(done_total - d0), 64'(1));
    chk("basic_mem5", 64'(mem[5]), 64'(32'h11121314));
    chk("basic_mem6", 64'(mem[6]), 64'(32'h15161718));
    chk("model_mem5", 64'(exp_mem[5]), 64'(32'h11121314));

    // Backpressure gaps
    s0 = strobe_total;
    for (int i = 0; i < 4; i++) tx[i] = 8'(8'hA1 + i);
    pat = '{1, 0, 0, 1, 1, 0, 1};
    do_start(20, 4);
    for (int k = 0; k < 7; k++) begin
      in_valid = pat[k];
      in_data  = tx[strobe_total - s0 < 4 ? 0 : 0];
      in_data  = 8'(8'hA1 + (pat[0] + (k > 0 ? 0 : 0)));
      in_data  = tx[(k == 0) ? 0 : (k <= 3) ? 1 : (k == 4) ? 2 : 3];
      tick();
    end
    in_valid = 1'b0;
    wait_idle();
    chk("gap_strobes", 64'(strobe_total - s0), 64'(4));
    chk("gap_mem20", 64'(mem[20]), 64'(32'hA1A2A3A4));

    // Partial word and zero length
    pre_addr = 9; pre_val = 32'hAABBCCDD; pre_seq++;
    tick(); tick();
    tx[0] = 8'h01; tx[1] = 8'h02;
    do_start(9, 2);
    send(2, 60, cyc);
    wait_idle();
    chk("partial_mem9", 64'(mem[9]), 64'(32'h0102CCDD));
    s0 = strobe_total; d0 = done_total;
    do_start(9, 0);
    @(negedge clk);
    chk("zero_len_done", 64'(done), 64'(1));
    wait_idle();
    chk("zero_len_strobes", 64'(strobe_total - s0), 64'(0));
    chk("zero_len_dones", 64'(done_total - d0), 64'(1));

    // Wrap-around
    for (int i = 0; i < 8; i++) tx[i] = 8'(8'hC0 + i);
    do_start(255, 8);
    send(8, 70, cyc);
    wait_idle();
    chk("wrap_mem255", 64'(mem[255]), 64'(32'hC0C1C2C3));
    chk("wrap_mem0", 64'(mem[0]), 64'(32'hC4C5C6C7));
    mem_all("wrap_mem_all");

    // Ignored start, then reset after 5 bytes
    for (int i = 0; i < 8; i++) tx[i] = 8'(8'hD0 + i);
    do_start(40, 8);
    send(2, 100, cyc);
    start = 1'b1; base_addr = 10'd100; num_bytes = 11'd3;
    for (int i = 0; i < 3; i++) tx[i] = tx[i + 2];
    send(3, 100, cyc);
    start = 1'b0;
    rst = 1'b1;
    tick();
    @(negedge clk);
    chk("reset_mid", {sram_csb, sram_wsb, busy, in_ready}, {1'b1, 1'b1, 1'b0, 1'b0});
    tick();
    rst = 1'b0;
    tick(); tick();
    chk("abort_mem40", 64'(mem[40]), 64'(32'hD0D1D2D3));
    chk("abort_mem41", 64'(mem[41]), 64'(32'hD4000000));
    mem_all("abort_mem_all");

    // Randomized transfers
    for (int t = 0; t < 10; t++) begin
      int len;
      len = ($urandom_range(3) == 0) ? $urandom_range(3) : $urandom_range(40);
      for (int i = 0; i < len; i++) tx[i] = 8'($urandom);
      do_start($urandom_range(255), len);
      if (len > 0) send(len, $urandom_range(100, 25), cyc);
      wait_idle();
      mem_all("rand_mem_all");
    end

    // Full 1024-byte load at full rate
    for (int i = 0; i < 1024; i++) tx[i] = 8'($urandom);
    s0 = strobe_total;
    do_start($urandom_range(255), 1024);
    send(1024, 100, cyc);
    chk("full_cycles", 64'(cyc), 64'(1024));
    @(negedge clk);
    chk("full_done", 64'(done), 64'(1));
    wait_idle();
    chk("full_strobes", 64'(strobe_total - s0), 64'(1024));
    mem_all("full_mem_all");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sram_byte_writer.md
Name: sram_byte_writer

Overview:
- Write-side initiator for the 256x32b byte-lane SRAM.
- Accepts a valid/ready stream of signed 8-bit values (weights or activations) and turns each byte into one SRAM byte-lane write, using a one-hot bytemask.
- Packs four bytes per word from MSB lane down, advances the word address, and reports completion.
- Sits between the host/DMA load path and the SRAM write port in the TPU buffer hierarchy.

Parameters:
- ADDR_W, 10: width of sram_waddr and base_addr.
- DEPTH, 256: number of 32-bit SRAM words. Word address wraps modulo DEPTH.
- LEN_W, 11: width of num_bytes. Maximum transfer is 4*DEPTH = 1024 bytes.

Ports:
- clk  in  1  clock. All logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request. Sampled only in IDLE.
- base_addr  in  ADDR_W  first word address. Captured on an accepted start.
- num_bytes  in  LEN_W  byte count. Captured on an accepted start.
- in_valid  in  1  input byte valid.
- in_data  in  8  input byte.
- in_ready  out  1  the block can accept a byte this cycle.
- sram_csb  out  1  SRAM chip enable, active low.
- sram_wsb  out  1  SRAM write enable, active low.
- sram_bytemask  out  4  one-hot lane select.
- sram_wdata  out  8  byte to write.
- sram_waddr  out  ADDR_W  word address.
- busy  out  1  high whenever the state is not IDLE.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset values: in_ready=0, sram_csb=1, sram_wsb=1, sram_bytemask=0000, sram_wdata=0, sram_waddr=0, busy=0, done=0. Internal state goes to IDLE, byte counter=0, lane=0.
- Reset mid-transfer: the transfer aborts at the reset edge and strobes deassert at that edge. A lane already written stays written and no further writes occur.
- All SRAM-side outputs are registered.
- State IDLE:
  - in_ready=0.
  - On start=1: capture base_addr and num_bytes, set lane=3 (mask 1000).
  - If num_bytes==0, go to DONE. Otherwise go to WRITE.
- State WRITE:
  - in_ready=1, combinational on state only and independent of in_valid.
  - A handshake (in_valid & in_ready) at edge t produces at the next edge: sram_csb=0, sram_wsb=0, sram_wdata=in_data, sram_waddr=current word address, sram_bytemask=one-hot(lane). The strobe is visible for exactly one cycle, so the SRAM captures it at edge t+1.
  - Lane order per word is 1000, 0100, 0010, 0001, i.e. the first byte lands in [31:24].
  - After lane 0001, the address increments and lane returns to 1000.
  - Address wraps from DEPTH-1 to 0.
  - A cycle without a handshake gives sram_csb=1, sram_wsb=1, mask=0000. Data and address hold.
  - After the handshake for byte num_bytes-1, go to DONE. in_ready drops in the cycle after that handshake.
- State DONE:
  - Lasts one cycle: done=1, busy=1, then IDLE.
  - The final write strobe and done are asserted in the same cycle.
- The write strobe is never asserted with a non-one-hot mask. This is critical: the SRAM zeroes the whole word on any other mask.
- A partial final word (num_bytes not a multiple of 4) leaves the unwritten lanes untouched. There is no padding write.
- start while busy is ignored and does not restart the transfer.
- in_valid outside WRITE is ignored and no byte is consumed.
- Throughput is one byte per cycle with continuous in_valid. A full 1024-byte load takes 1024 WRITE cycles plus 1 DONE cycle.
- Read port: the block never drives raddr. A reader that shares csb must hold off while busy.

Test Plan:
- Basic pack: reset, start with base_addr=5, num_bytes=8, stream 0x11..0x18 back-to-back.
  - Required: 8 consecutive strobes. Masks 1000, 0100, 0010, 0001 at addr 5, then the same at addr 6.
  - Backdoor read: mem[5]=0x11121314, mem[6]=0x15161718. done pulses once, busy falls the cycle after.
- Backpressure gaps: num_bytes=4 with in_valid toggling 1,0,0,1,1,0,1.
  - Required: exactly 4 strobes, each one cycle after its handshake. Idle cycles show csb=1, mask=0000. mem[base]=data packed MSB-first.
- Partial word and zero length: preload mem[9]=0xAABBCCDD, then num_bytes=2 bytes 0x01, 0x02 at addr 9.
  - Required: mem[9]=0x0102CCDD.
  - Then start with num_bytes=0: done pulses one cycle after start, zero strobes.
- Wrap-around: base_addr=255, num_bytes=8.
  - Required: bytes 0-3 written to addr 255, bytes 4-7 to addr 0. No other address is touched.
- Ignored start and mid-run reset: pulse start again during an 8-byte transfer; it has no effect on addr or count.
  - Then assert rst after 5 bytes. The next cycle shows csb=1, wsb=1, busy=0, in_ready=0.
  - Only words base (full) and base+1 lane [31:24] are modified.
- Mask invariant (assertion over all tests): whenever sram_wsb==0, sram_bytemask is in {0001, 0010, 0100, 1000} and sram_csb==0.
